// File: rtl/btb_redirect_unit.sv
// Direct-mapped branch target buffer with fetch-time lookup, IF/ID/EX prediction tracking,
// EX-stage mispredict detection, registered fetch redirect and saturating mispredict count.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module btb_redirect_unit #(
    parameter int BTB_ENTRIES = 64,
    parameter int BTB_IDX_W   = $clog2(BTB_ENTRIES),
    parameter int TAG_W       = `ADDR_WIDTH - BTB_IDX_W - 2
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rstn,
    input  logic [`ADDR_WIDTH-1:0] next_pc,
    input  logic [1:0]             predictor,
    input  logic                   if_advance,
    input  logic                   id_advance,
    input  logic                   ex_valid,
    input  logic                   ex_flush,
    input  logic                   branch_ex,
    input  logic                   branch_taken_ex,
    input  logic [`ADDR_WIDTH-1:0] branch_pc_ex,
    input  logic [`ADDR_WIDTH-1:0] branch_target_ex,
    output logic                   pred_taken,
    output logic [`ADDR_WIDTH-1:0] pred_target,
    output logic                   redirect_valid,
    output logic [`ADDR_WIDTH-1:0] redirect_pc,
    output logic [31:0]            mispredict_cnt
);

    localparam int AW = `ADDR_WIDTH;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [AW-1:0]          btb_target [BTB_ENTRIES];

    logic [BTB_IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0]     rd_tag;
    logic                 rd_hit;

    logic          rec_id_v;
    logic          rec_id_taken;
    logic [AW-1:0] rec_id_target;
    logic          rec_ex_v;
    logic          rec_ex_taken;
    logic [AW-1:0] rec_ex_target;

    logic                 ev;
    logic                 pt;
    logic                 mp;
    logic                 btb_wr;
    logic                 btb_inv;
    logic [BTB_IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0]     ex_tag;
    logic [AW-1:0]        fix_pc;

    // Word-offset bits and the counter's hysteresis bit play no part here.
    logic unused_bits;
    assign unused_bits = ^{next_pc[1:0], branch_pc_ex[1:0], predictor[0]};

    assign rd_idx      = next_pc[BTB_IDX_W+1:2];
    assign rd_tag      = next_pc[AW-1:BTB_IDX_W+2];
    assign rd_hit      = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
    assign pred_taken  = rd_hit && predictor[1];
    assign pred_target = rd_hit ? btb_target[rd_idx] : '0;

    assign ev     = ex_valid && !ex_flush;
    assign pt     = rec_ex_v && rec_ex_taken;
    assign ex_idx = branch_pc_ex[BTB_IDX_W+1:2];
    assign ex_tag = branch_pc_ex[AW-1:BTB_IDX_W+2];

    always_comb begin
        mp = 1'b0;
        if (branch_ex) begin
            if (branch_taken_ex != pt)
                mp = 1'b1;
            else if (branch_taken_ex && pt && (branch_target_ex != rec_ex_target))
                mp = 1'b1;
        end else if (pt) begin
            mp = 1'b1;
        end
    end

    // A false hit has no meaningful direction, so only real taken branches leave the fall-through path.
    assign fix_pc  = (branch_ex && branch_taken_ex) ? branch_target_ex : branch_pc_ex + AW'(4);
    assign btb_wr  = ev && branch_ex && branch_taken_ex;
    assign btb_inv = ev && !branch_ex && pt;

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            btb_valid <= '0;
        end else if (btb_wr) begin
            btb_valid[ex_idx] <= 1'b1;
        end else if (btb_inv) begin
            btb_valid[ex_idx] <= 1'b0;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (btb_wr) begin
            btb_tag[ex_idx]    <= ex_tag;
            btb_target[ex_idx] <= branch_target_ex;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            rec_id_v      <= 1'b0;
            rec_id_taken  <= 1'b0;
            rec_id_target <= '0;
            rec_ex_v      <= 1'b0;
            rec_ex_taken  <= 1'b0;
            rec_ex_target <= '0;
        end else if (ex_flush || (ev && mp)) begin
            rec_id_v <= 1'b0;
            rec_ex_v <= 1'b0;
        end else begin
            if (if_advance) begin
                rec_id_v      <= 1'b1;
                rec_id_taken  <= pred_taken;
                rec_id_target <= pred_target;
            end else if (id_advance) begin
                rec_id_v <= 1'b0;
            end
            if (id_advance) begin
                rec_ex_v      <= rec_id_v;
                rec_ex_taken  <= rec_id_taken;
                rec_ex_target <= rec_id_target;
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
        end else begin
            redirect_valid <= ev && mp;
            if (ev && mp) begin
                redirect_pc <= fix_pc;
                if (mispredict_cnt != 32'hFFFF_FFFF)
                    mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_btb_redirect_unit.sv
// Directed bench for btb_redirect_unit: each task drives one scenario and checks
// hand-computed lookup, redirect and counter values.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_btb_redirect_unit;

    localparam int AW = `ADDR_WIDTH;

    logic          cpu_clk;
    logic          cpu_rstn;
    logic [AW-1:0] next_pc;
    logic [1:0]    predictor;
    logic          if_advance;
    logic          id_advance;
    logic          ex_valid;
    logic          ex_flush;
    logic          branch_ex;
    logic          branch_taken_ex;
    logic [AW-1:0] branch_pc_ex;
    logic [AW-1:0] branch_target_ex;
    logic          pred_taken;
    logic [AW-1:0] pred_target;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic [31:0]   mispredict_cnt;

    int total = 0;
    int bad   = 0;

    btb_redirect_unit dut (
        .cpu_clk         (cpu_clk),
        .cpu_rstn        (cpu_rstn),
        .next_pc         (next_pc),
        .predictor       (predictor),
        .if_advance      (if_advance),
        .id_advance      (id_advance),
        .ex_valid        (ex_valid),
        .ex_flush        (ex_flush),
        .branch_ex       (branch_ex),
        .branch_taken_ex (branch_taken_ex),
        .branch_pc_ex    (branch_pc_ex),
        .branch_target_ex(branch_target_ex),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .mispredict_cnt  (mispredict_cnt)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic idle();
        if_advance       = 1'b0;
        id_advance       = 1'b0;
        ex_valid         = 1'b0;
        ex_flush         = 1'b0;
        branch_ex        = 1'b0;
        branch_taken_ex  = 1'b0;
        branch_pc_ex     = '0;
        branch_target_ex = '0;
    endtask

    task automatic set_ex(input logic br, input logic tk, input logic [AW-1:0] pc, input logic [AW-1:0] tgt);
        ex_valid         = 1'b1;
        branch_ex        = br;
        branch_taken_ex  = tk;
        branch_pc_ex     = pc;
        branch_target_ex = tgt;
    endtask

    // Fetch 'pc' predicted strongly taken and walk its record into EX.
    task automatic load_record(input logic [AW-1:0] pc);
        idle();
        next_pc    = pc;
        predictor  = 2'b11;
        if_advance = 1'b1;
        step();
        if_advance = 1'b0;
        id_advance = 1'b1;
        step();
        id_advance = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        cpu_rstn  = 1'b0;
        next_pc   = 32'h100;
        predictor = 2'b11;
        repeat (2) @(posedge cpu_clk);
        #1;
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred_taken got=%0h want=0", pred_taken); end
        total++; if (pred_target !== 32'h0) begin bad++; $display("FAIL reset_pred_target got=%0h want=0", pred_target); end
        total++; if (mispredict_cnt !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%0h want=0", mispredict_cnt); end
        total++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_redirect got=%0h/%0h want=0/0", redirect_valid, redirect_pc); end
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        step();
    endtask

    task automatic test_cold_miss();
        idle();
        set_ex(1'b1, 1'b1, 32'h100, 32'h200);
        step();
        idle();
        total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL cold_redirect_valid got=%0h want=1", redirect_valid); end
        total++; if (redirect_pc !== 32'h200) begin bad++; $display("FAIL cold_redirect_pc got=%0h want=200", redirect_pc); end
        total++; if (mispredict_cnt !== 32'd1) begin bad++; $display("FAIL cold_cnt got=%0h want=1", mispredict_cnt); end
        step();
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL cold_one_cycle got=%0h want=0", redirect_valid); end
        next_pc   = 32'h100;
        predictor = 2'b10;
        #1;
        total++; if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin bad++; $display("FAIL cold_lookup got=%0h/%0h want=1/200", pred_taken, pred_target); end
        predictor = 2'b01;
        #1;
        total++; if (pred_taken !== 1'b0 || pred_target !== 32'h200) begin bad++; $display("FAIL cold_lookup_nt got=%0h/%0h want=0/200", pred_taken, pred_target); end
    endtask

    task automatic test_correct_and_dir_miss();
        load_record(32'h100);
        set_ex(1'b1, 1'b1, 32'h100, 32'h200);
        step();
        idle();
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL correct_no_redirect got=%0h want=0", redirect_valid); end
        total++; if (mispredict_cnt !== 32'd1) begin bad++; $display("FAIL correct_cnt got=%0h want=1", mispredict_cnt); end
        load_record(32'h100);
        set_ex(1'b1, 1'b0, 32'h100, 32'h200);
        step();
        idle();
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104) begin bad++; $display("FAIL dirmiss_redirect got=%0h/%0h want=1/104", redirect_valid, redirect_pc); end
        total++; if (mispredict_cnt !== 32'd2) begin bad++; $display("FAIL dirmiss_cnt got=%0h want=2", mispredict_cnt); end
        next_pc = 32'h100; predictor = 2'b11;
        #1;
        total++; if (pred_target !== 32'h200) begin bad++; $display("FAIL dirmiss_btb_kept got=%0h want=200", pred_target); end
    endtask

    task automatic test_wrong_target();
        load_record(32'h100);
        set_ex(1'b1, 1'b1, 32'h100, 32'h300);
        step();
        idle();
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin bad++; $display("FAIL tgtmiss_redirect got=%0h/%0h want=1/300", redirect_valid, redirect_pc); end
        total++; if (mispredict_cnt !== 32'd3) begin bad++; $display("FAIL tgtmiss_cnt got=%0h want=3", mispredict_cnt); end
        next_pc = 32'h100; predictor = 2'b11;
        #1;
        total++; if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin bad++; $display("FAIL tgtmiss_btb got=%0h/%0h want=1/300", pred_taken, pred_target); end
    endtask

    task automatic test_false_hit();
        load_record(32'h100);
        set_ex(1'b0, 1'b1, 32'h100, 32'h900);
        step();
        idle();
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104) begin bad++; $display("FAIL falsehit_redirect got=%0h/%0h want=1/104", redirect_valid, redirect_pc); end
        total++; if (mispredict_cnt !== 32'd4) begin bad++; $display("FAIL falsehit_cnt got=%0h want=4", mispredict_cnt); end
        next_pc = 32'h100; predictor = 2'b11;
        #1;
        total++; if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin bad++; $display("FAIL falsehit_inval got=%0h/%0h want=0/0", pred_taken, pred_target); end
    endtask

    task automatic test_same_cycle_rw();
        idle();
        next_pc = 32'h100; predictor = 2'b11;
        set_ex(1'b1, 1'b1, 32'h100, 32'h400);
        #1;
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL rw_old_view got=%0h want=0", pred_taken); end
        step();
        idle();
        total++; if (pred_taken !== 1'b1 || pred_target !== 32'h400) begin bad++; $display("FAIL rw_new_view got=%0h/%0h want=1/400", pred_taken, pred_target); end
        total++; if (redirect_pc !== 32'h400 || mispredict_cnt !== 32'd5) begin bad++; $display("FAIL rw_redirect got=%0h cnt=%0h want=400 cnt=5", redirect_pc, mispredict_cnt); end
    endtask

    task automatic test_back_to_back();
        idle();
        next_pc = 32'h100; predictor = 2'b11; if_advance = 1'b1;
        step();
        next_pc = 32'h500; id_advance = 1'b1;
        step();
        if_advance = 1'b0;
        set_ex(1'b1, 1'b1, 32'h100, 32'h400);
        step();
        id_advance = 1'b0;
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL b2b_first got=%0h want=0", redirect_valid); end
        set_ex(1'b1, 1'b0, 32'h500, 32'h0);
        step();
        idle();
        total++; if (redirect_valid !== 1'b0 || mispredict_cnt !== 32'd5) begin bad++; $display("FAIL b2b_second got=%0h cnt=%0h want=0 cnt=5", redirect_valid, mispredict_cnt); end
    endtask

    task automatic test_flush();
        load_record(32'h100);
        set_ex(1'b1, 1'b1, 32'h100, 32'h800);
        ex_flush = 1'b1;
        step();
        idle();
        total++; if (redirect_valid !== 1'b0 || mispredict_cnt !== 32'd5) begin bad++; $display("FAIL flush_redirect got=%0h cnt=%0h want=0 cnt=5", redirect_valid, mispredict_cnt); end
        next_pc = 32'h100; predictor = 2'b11;
        #1;
        total++; if (pred_target !== 32'h400) begin bad++; $display("FAIL flush_no_write got=%0h want=400", pred_target); end
        set_ex(1'b0, 1'b0, 32'h100, 32'h0);
        step();
        idle();
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL flush_rec_inval got=%0h want=0", redirect_valid); end
    endtask

    task automatic test_saturation();
        idle();
        force dut.mispredict_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.mispredict_cnt;
        set_ex(1'b1, 1'b1, 32'h900, 32'hA00);
        step();
        total++; if (mispredict_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_reach got=%0h want=ffffffff", mispredict_cnt); end
        step();
        idle();
        total++; if (mispredict_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_hold got=%0h want=ffffffff", mispredict_cnt); end
    endtask

    task automatic test_reset_mid();
        idle();
        set_ex(1'b1, 1'b1, 32'hC00, 32'hD00);
        step();
        idle();
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'hD00) begin bad++; $display("FAIL midrst_pre got=%0h/%0h want=1/d00", redirect_valid, redirect_pc); end
        cpu_rstn = 1'b0;
        #1;
        total++; if (redirect_valid !== 1'b0 || mispredict_cnt !== 32'h0) begin bad++; $display("FAIL midrst_async got=%0h cnt=%0h want=0 cnt=0", redirect_valid, mispredict_cnt); end
        next_pc = 32'hC00; predictor = 2'b11;
        #1;
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL midrst_btb got=%0h want=0", pred_taken); end
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_correct_and_dir_miss();
        test_wrong_target();
        test_false_hit();
        test_same_cycle_rw();
        test_back_to_back();
        test_flush();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btb_redirect_unit.md
Name: btb_redirect_unit

Overview:
- Fetch-side branch target buffer plus EX-side resolution and redirect logic for the 2-level 2b direction predictor.
- Consumes the predictor's 2-bit counter for next_pc and combines it with a BTB hit to produce a fetch-time predicted-taken/target.
- Carries each prediction down the IF/ID/EX pipe and compares it with the resolved outcome in EX.
- Issues a registered one-cycle redirect on mispredict, and trains the BTB and a mispredict counter.

Parameters:
BTB_ENTRIES, 64, number of direct-mapped BTB entries (power of 2)
BTB_IDX_W, $clog2(BTB_ENTRIES), index width; index = pc[BTB_IDX_W+1:2]
TAG_W, `ADDR_WIDTH-BTB_IDX_W-2, tag width; tag = pc[`ADDR_WIDTH-1:BTB_IDX_W+2]

Ports:
cpu_clk  in  1  core clock
cpu_rstn  in  1  async active-low reset
next_pc  in  `ADDR_WIDTH  PC being fetched (same value driven to the direction predictor)
predictor  in  2  2b counter for next_pc; bit[1]=1 means predict taken
if_advance  in  1  fetch of next_pc accepted into IF/ID this cycle
id_advance  in  1  ID instruction moves to EX this cycle
ex_valid  in  1  EX holds a valid instruction this cycle
ex_flush  in  1  trap/exception flush from later stage
branch_ex  in  1  EX instruction is a conditional branch or jump
branch_taken_ex  in  1  resolved direction
branch_pc_ex  in  `ADDR_WIDTH  PC of EX instruction
branch_target_ex  in  `ADDR_WIDTH  resolved target
pred_taken  out  1  combinational: BTB hit && predictor[1]
pred_target  out  `ADDR_WIDTH  combinational: BTB target at next_pc index (0 on miss)
redirect_valid  out  1  registered one-cycle fetch redirect
redirect_pc  out  `ADDR_WIDTH  registered redirect address
mispredict_cnt  out  32  saturating mispredict count

Behaviour:
- Clock cpu_clk; reset cpu_rstn, asynchronous, active-low. Reset clears all BTB valid bits (tags/targets need not reset), rec_id/rec_ex valid, redirect_valid=0, redirect_pc=0, mispredict_cnt=0.
- Lookup is combinational from next_pc. hit = valid[idx] && tag[idx]==tag(next_pc). pred_taken = hit && predictor[1]. pred_target = hit ? target[idx] : 0.
- Prediction record {v, taken, target}:
  - If if_advance: rec_id <= {1, pred_taken, pred_target}.
  - If id_advance: rec_ex <= rec_id.
  - id_advance without if_advance: rec_id.v <= 0.
  - Both asserted in the same cycle: shift (rec_ex gets the old rec_id, rec_id gets the new fetch).
- Resolution happens when ev = ex_valid && !ex_flush. Effective prediction: pt = rec_ex.v && rec_ex.taken; ptgt = rec_ex.target. Mispredict mp is true when any of:
  - branch_ex and branch_taken_ex != pt;
  - branch_ex and branch_taken_ex and pt and branch_target_ex != ptgt;
  - !branch_ex and pt (false hit).
- On ev && mp, at the next edge:
  - redirect_valid <= 1.
  - redirect_pc <= branch_taken_ex ? branch_target_ex : branch_pc_ex+4. For a false hit, redirect_pc = branch_pc_ex+4.
  - rec_id.v <= 0 and rec_ex.v <= 0, overriding the advances.
  - mispredict_cnt <= mispredict_cnt+1, holding at 32'hFFFF_FFFF.
- redirect_valid is high for exactly one cycle per mispredict; otherwise 0. redirect_pc holds its last value.
- ex_flush clears rec_id.v and rec_ex.v at the next edge, with priority over advances. No redirect, no BTB update, no count.
- BTB update (ev only, index/tag from branch_pc_ex):
  - branch_ex && branch_taken_ex: write valid=1, tag, target=branch_target_ex. Applies whether or not mispredicted.
  - !branch_ex && pt: clear valid at that index.
  - Not-taken branches leave the BTB unchanged.
- Same-cycle read and write to one index: the lookup sees the old contents; the new contents are visible next cycle.
- Aliasing: a write always overwrites the existing entry (direct-mapped, no replacement policy).
- The EX-to-redirect latency is 1 cycle, and the fetch consumer gives redirect priority over next_pc.

Test Plan:
1. After reset, next_pc=0x100, predictor=2'b11 → pred_taken=0, pred_target=0; mispredict_cnt=0.
2. EX: ev, branch_ex=1, taken=1, pc=0x100, target=0x200, rec_ex.v=0 → next cycle redirect_valid=1 for one cycle, redirect_pc=0x200, cnt=1. Later next_pc=0x100, predictor=2'b10 → pred_taken=1, pred_target=0x200.
3. Predicted taken to 0x200 carried through if_advance/id_advance; EX resolves taken, target 0x200 → no redirect, cnt unchanged. Same record but taken=0 → redirect_pc=0x104, cnt+1.
4. Same record resolved taken to target 0x300 → redirect_pc=0x300, and the BTB entry target becomes 0x300.
5. False hit: pt=1 with branch_ex=0 at pc 0x100 → redirect_pc=0x104, entry invalidated; next lookup of 0x100 gives pred_taken=0.
6. Concurrency and saturation:
   - ex_flush with ex_valid and a would-be mispredict → no redirect, no BTB write, records invalidated.
   - Preload cnt to 0xFFFF_FFFF, then a mispredict → cnt stays 0xFFFF_FFFF.
   - Assert cpu_rstn low mid-redirect → redirect_valid drops immediately.
